// File: rtl/ser_pkg.sv
// -----------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the tx_fifo_ser serial transmitter:
//   - tx_state_e      : transmitter state encoding (IDLE/START/DATA/STOP)
//   - LAST_DATA_BIT   : index of the final data bit of an 8N1 frame
//   - calc_bit_clocks : clock cycles per serial bit (CLOCK_HZ / BAUD)
//   - calc_bit_reload : value loaded into the 32-bit down-counter per bit
//   - ptr_width       : pointer width for a power-of-two byte queue
// -----------------------------------------------------------------------------
package ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam logic [2:0] LAST_DATA_BIT = 3'd7;

   // Cycles per serial bit; integer division truncates any remainder.
   function automatic int unsigned calc_bit_clocks(input int unsigned clock_hz,
                                                   input int unsigned baud);
      return clock_hz / baud;
   endfunction

   // The bit counter runs BIT_CLOCKS-1 down to 0. A degenerate ratio below
   // one cycle per bit is clamped so every bit still lasts one cycle.
   function automatic logic [31:0] calc_bit_reload(input int unsigned clock_hz,
                                                   input int unsigned baud);
      int unsigned bc;
      bc = calc_bit_clocks(clock_hz, baud);
      if (bc == 32'd0) begin
         return 32'd0;
      end else begin
         return bc - 32'd1;
      end
   endfunction

   // Pointer width for a power-of-two queue depth (at least one bit).
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 32'd1) ? $clog2(depth) : 32'd1;
   endfunction

endpackage

// File: rtl/ser_fifo.sv
// -----------------------------------------------------------------------------
// ser_fifo
// Small byte queue feeding the serial transmitter.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-low reset; empties the queue
//   wr, wdata  : enqueue strobe and byte; ignored while full (even if a read
//                happens in the same cycle)
//   rd         : dequeue strobe; ignored while empty
//   rdata      : head-of-queue byte (valid while empty=0)
//   full       : registered, queue holds DEPTH entries
//   empty      : registered, queue holds no entries
//   empty_next : occupancy after the coming edge is zero (lets the parent
//                register its own status flags in step with the queue)
// -----------------------------------------------------------------------------
module ser_fifo
   import ser_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic             empty_next
);

   localparam int unsigned      PTR_W    = ptr_width(DEPTH);
   localparam int unsigned      CNT_W    = PTR_W + 32'd1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_wr;
   logic             do_rd;

   // Next-state computation for storage, pointers, occupancy and flags.
   always_comb begin
      do_wr    = wr && !full_q;
      do_rd    = rd && !empty_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      if (do_wr) begin
         mem_d[wr_ptr_q] = wdata;
         // Power-of-two depth: natural pointer overflow is the modulo wrap.
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      full_d  = (count_d == CNT_FULL);
      empty_d = (count_d == CNT_ZERO);
   end

   // Queue state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= CNT_ZERO;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign rdata      = mem_q[rd_ptr_q];
   assign full       = full_q;
   assign empty      = empty_q;
   assign empty_next = empty_d;

endmodule

// File: rtl/tx_fifo_ser.sv
// -----------------------------------------------------------------------------
// tx_fifo_ser
// Queued 8N1 serial transmitter. Bytes written on the parallel side are held
// in a FIFO_DEPTH-entry queue and sent LSB first, framed by a low start bit
// and a high stop bit, each bit lasting CLOCK_HZ/BAUD cycles. Queued frames
// go out back to back with no idle gap.
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous active-low reset; aborts any frame, empties queue
//   write       : one-cycle strobe enqueueing parallel_in (dropped when full)
//   parallel_in : byte to transmit, sampled only on an accepted write
//   full        : registered, queue holds FIFO_DEPTH bytes
//   busy        : registered, frame in progress or queue non-empty
//   serial_out  : registered serial line, idle high
// -----------------------------------------------------------------------------
module tx_fifo_ser
   import ser_pkg::*;
#(
   parameter int unsigned CLOCK_HZ   = 50000000,
   parameter int unsigned BAUD       = 10000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       write,
   input  logic [7:0] parallel_in,
   output logic       full,
   output logic       busy,
   output logic       serial_out
);

   localparam logic [31:0] BIT_RELOAD = calc_bit_reload(CLOCK_HZ, BAUD);

   tx_state_e   state_q, state_d;
   logic [31:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        serial_q, serial_d;
   logic        busy_q, busy_d;

   logic        pop;
   logic        bit_expired;
   logic [7:0]  fifo_rdata;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_empty_next;

   ser_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .wr         (write),
      .wdata      (parallel_in),
      .rd         (pop),
      .rdata      (fifo_rdata),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .empty_next (fifo_empty_next)
   );

   // Transmitter next-state logic: bit timing, framing and queue pops.
   always_comb begin
      bit_expired = (bit_cnt_q == 32'd0);
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      serial_d    = serial_q;
      pop         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               // Start bit goes out on the same edge that pops the head.
               pop       = 1'b1;
               state_d   = ST_START;
               bit_cnt_d = BIT_RELOAD;
               shift_d   = fifo_rdata;
               serial_d  = 1'b0;
            end else begin
               serial_d = 1'b1;
            end
         end

         ST_START: begin
            if (bit_expired) begin
               state_d   = ST_DATA;
               bit_cnt_d = BIT_RELOAD;
               bit_idx_d = 3'd0;
               serial_d  = shift_q[0];
            end else begin
               bit_cnt_d = bit_cnt_q - 32'd1;
            end
         end

         ST_DATA: begin
            if (bit_expired) begin
               bit_cnt_d = BIT_RELOAD;
               if (bit_idx_q == LAST_DATA_BIT) begin
                  state_d  = ST_STOP;
                  serial_d = 1'b1;
               end else begin
                  // shift_q[0] is on the line now; bit 1 is the next one out.
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  serial_d  = shift_q[1];
               end
            end else begin
               bit_cnt_d = bit_cnt_q - 32'd1;
            end
         end

         ST_STOP: begin
            if (bit_expired) begin
               if (!fifo_empty) begin
                  // Chain straight into the next frame: no idle gap.
                  pop       = 1'b1;
                  state_d   = ST_START;
                  bit_cnt_d = BIT_RELOAD;
                  shift_d   = fifo_rdata;
                  serial_d  = 1'b0;
               end else begin
                  state_d  = ST_IDLE;
                  serial_d = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - 32'd1;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = 32'd0;
            bit_idx_d = 3'd0;
            serial_d  = 1'b1;
         end
      endcase

      // Reflects both the transmitter and the queue as they stand after the edge.
      busy_d = (state_d != ST_IDLE) || !fifo_empty_next;
   end

   // Transmitter state and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 32'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         serial_q  <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         serial_q  <= serial_d;
         busy_q    <= busy_d;
      end
   end

   assign full       = fifo_full;
   assign busy       = busy_q;
   assign serial_out = serial_q;

endmodule

// File: tb/tb_tx_fifo_ser.sv
`timescale 1ns/1ps
module tb_tx_fifo_ser;

   localparam int unsigned CLOCK_HZ = 40;
   localparam int unsigned BAUD     = 10;
   localparam int unsigned DEPTH    = 4;
   localparam int          BC       = 4;        // cycles per bit
   localparam int          FRAME    = 10 * BC;  // cycles per 8N1 frame

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       write = 1'b0;
   logic [7:0] parallel_in = 8'd0;
   logic       full;
   logic       busy;
   logic       serial_out;

   tx_fifo_ser #(
      .CLOCK_HZ   (CLOCK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .write       (write),
      .parallel_in (parallel_in),
      .full        (full),
      .busy        (busy),
      .serial_out  (serial_out)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   // Reference model: queued bytes, byte on the wire, cycles left in frame.
   byte unsigned mq[$];
   byte unsigned sb_q[$];   // expected frames, popped by the monitor
   int           m_left = 0;
   byte unsigned m_cur = 8'd0;
   bit           chk_en = 1'b0;
   bit           mon_abort = 1'b0;
   int           frames = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Line level implied by the model: frame position -> start/data/stop bit.
   function automatic logic model_serial();
      int pos;
      int slot;
      if (m_left == 0) return 1'b1;
      pos  = FRAME - m_left;
      slot = pos / BC;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return m_cur[slot - 1];
   endfunction

   // Apply one clock edge to the model using the inputs present at that edge.
   function automatic void model_edge();
      bit pop;
      bit acc;
      if (!reset) begin
         mq.delete();
         sb_q.delete();
         m_left    = 0;
         mon_abort = 1'b1;
      end else begin
         pop = (m_left <= 1) && (mq.size() > 0);
         acc = write && (mq.size() < int'(DEPTH));
         if (pop) m_cur = mq.pop_front();
         if (acc) begin
            mq.push_back(parallel_in);
            sb_q.push_back(parallel_in);
         end
         if (pop) m_left = FRAME;
         else if (m_left > 0) m_left = m_left - 1;
         else m_left = 0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      chk_en = 1'b1;
      #1;
   endtask

   task automatic cyc(input logic w, input logic [7:0] d);
      write       = w;
      parallel_in = d;
      tick();
      write = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((m_left != 0 || mq.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      if (m_left != 0 || mq.size() != 0) begin
         vecs++;
         errs++;
         $display("FAIL wait_idle: timeout after %0d cycles", budget);
      end
      check("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   // Monitor: per-cycle line/flag check plus frame decoding against the scoreboard.
   initial begin : monitor
      bit          in_frame;
      int          off;
      logic [7:0]  rx;
      byte unsigned exp_b;
      in_frame = 1'b0;
      off      = 0;
      rx       = 8'd0;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("serial_out", {31'd0, serial_out}, {31'd0, model_serial()});
            check("full", {31'd0, full}, {31'd0, (mq.size() == int'(DEPTH))});
            check("busy", {31'd0, busy}, {31'd0, (m_left > 0 || mq.size() > 0)});
            if (mon_abort) begin
               in_frame  = 1'b0;
               mon_abort = 1'b0;
            end
            if (!in_frame) begin
               if (serial_out === 1'b0) begin
                  in_frame = 1'b1;
                  off      = 0;
               end
            end else begin
               off++;
            end
            if (in_frame) begin
               if (off == BC / 2) check("start_bit", {31'd0, serial_out}, 32'd0);
               if (off > BC && off < 9 * BC && (off % BC) == BC / 2)
                  rx[(off / BC) - 1] = serial_out;
               if (off == 9 * BC + BC / 2) begin
                  check("stop_bit", {31'd0, serial_out}, 32'd1);
                  if (sb_q.size() == 0) begin
                     vecs++;
                     errs++;
                     $display("FAIL unexpected_frame: got byte %0h, none expected", rx);
                  end else begin
                     exp_b = sb_q.pop_front();
                     check("rx_byte", {24'd0, rx}, {24'd0, exp_b});
                  end
                  frames++;
               end
               if (off == FRAME - 1) in_frame = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int n;
      int f0;
      reset = 1'b0;
      repeat (3) tick();
      check("rst_serial", {31'd0, serial_out}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      tick();

      // Single byte: start bit one cycle after the write, busy for the frame.
      cyc(1'b1, 8'hA5);
      check("a5_line_at_w", {31'd0, serial_out}, 32'd1);
      tick();
      check("a5_start_at_w1", {31'd0, serial_out}, 32'd0);
      n = 1;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      // One cycle of queue latency plus the 40-cycle frame.
      check("a5_busy_cycles", n, FRAME + 1);
      wait_idle(20);

      // Back-to-back frames.
      cyc(1'b1, 8'h00);
      cyc(1'b1, 8'hFF);
      wait_idle(150);

      // Overfill: 0x06 is dropped.
      f0 = frames;
      for (int i = 1; i <= 6; i++) cyc(1'b1, 8'(i));
      check("burst_full", {31'd0, full}, 32'd1);
      wait_idle(300);
      tick();
      check("burst_frames", frames - f0, 5);

      // Write while full on the STOP-expiry pop edge.
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom));
      n = 0;
      while (m_left != 1 && n < 60) begin
         tick();
         n++;
      end
      check("stop_edge_reached", m_left, 1);
      check("stop_edge_full", {31'd0, full}, 32'd1);
      cyc(1'b1, 8'hEE);
      check("stop_edge_after", {31'd0, full}, 32'd0);
      wait_idle(300);

      // Reset during data bit 3 of 0x3C with two bytes queued.
      cyc(1'b1, 8'h3C);
      cyc(1'b1, 8'h11);
      cyc(1'b1, 8'h22);
      n = 0;
      while (!(m_left <= FRAME - 4 * BC && m_left > FRAME - 5 * BC) && n < 60) begin
         tick();
         n++;
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("abort_serial", {31'd0, serial_out}, 32'd1);
      check("abort_full", {31'd0, full}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      f0 = frames;
      repeat (80) tick();
      check("abort_no_frames", frames - f0, 0);

      // Input changes after the write must not reach the wire.
      cyc(1'b1, 8'h5A);
      for (int i = 0; i < 45; i++) begin
         parallel_in = ~parallel_in;
         tick();
      end
      wait_idle(100);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         write       = ($urandom_range(0, 3) == 0);
         parallel_in = 8'($urandom);
         reset       = ($urandom_range(0, 199) != 0);
         tick();
         write = 1'b0;
         reset = 1'b1;
      end
      wait_idle(400);
      repeat (3) tick();
      check("scoreboard_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
